// File: rtl/hazard_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_pipe_ctrl
//
// Control-side pipeline register chain and load-use hazard detector for the
// 5-stage MIPS core. It carries RegWrite, MemRead and the register
// specifiers through the ID/EX, EX/MEM and MEM/WB stages. The registered
// stage outputs are the values the forwarding unit compares against.
//
// The block also:
//   - stalls one cycle on a load-use hazard,
//   - inserts a bubble into ID/EX when a branch or jump flushes ID,
//   - freezes every stage while memory is not ready,
//   - keeps a saturating count of load-use stall cycles.
//
// Ports
//   clk_i, rst_i               core clock, synchronous active-high reset
//   IF_ID_RegisterRs/Rt        source specifiers of the instruction in ID
//   ID_RegisterRd              destination of the instruction in ID (RegDst-muxed)
//   ID_RegWrite, ID_MemRead    decoded control bits of the instruction in ID
//   flush_i                    instruction in ID is wrong-path
//   mem_stall_i                freeze the whole pipeline this cycle
//   ID_EX_*                    ID/EX stage register contents
//   EX_MEM_*                   EX/MEM stage register contents
//   MEM_WB_*                   MEM/WB stage register contents
//   PCWrite, IF_ID_Write       update enables for the PC and the IF/ID register
//   load_use_stall             a load-use stall is being taken this cycle
//   stall_count                saturating count of load-use stall cycles
// ---------------------------------------------------------------------------
module hazard_pipe_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic [4:0]       IF_ID_RegisterRs,
    input  logic [4:0]       IF_ID_RegisterRt,
    input  logic [4:0]       ID_RegisterRd,
    input  logic             ID_RegWrite,
    input  logic             ID_MemRead,
    input  logic             flush_i,
    input  logic             mem_stall_i,

    output logic [4:0]       ID_EX_RegisterRs,
    output logic [4:0]       ID_EX_RegisterRt,
    output logic [4:0]       ID_EX_RegisterRd,
    output logic             ID_EX_RegWrite,
    output logic             ID_EX_MemRead,

    output logic             EX_MEM_RegWrite,
    output logic             EX_MEM_MemRead,
    output logic [4:0]       EX_MEM_RegisterRd,

    output logic             MEM_WB_RegWrite,
    output logic [4:0]       MEM_WB_RegisterRd,

    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             load_use_stall,
    output logic [CNT_W-1:0] stall_count
);

    // -----------------------------------------------------------------------
    // Stage registers
    // -----------------------------------------------------------------------
    logic [4:0]       id_ex_rs_reg,   id_ex_rs_next;
    logic [4:0]       id_ex_rt_reg,   id_ex_rt_next;
    logic [4:0]       id_ex_rd_reg,   id_ex_rd_next;
    logic             id_ex_rw_reg,   id_ex_rw_next;
    logic             id_ex_mr_reg,   id_ex_mr_next;

    logic             ex_mem_rw_reg,  ex_mem_rw_next;
    logic             ex_mem_mr_reg,  ex_mem_mr_next;
    logic [4:0]       ex_mem_rd_reg,  ex_mem_rd_next;

    logic             mem_wb_rw_reg,  mem_wb_rw_next;
    logic [4:0]       mem_wb_rd_reg,  mem_wb_rd_next;

    logic [CNT_W-1:0] stall_cnt_reg,  stall_cnt_next;

    // -----------------------------------------------------------------------
    // Load-use hazard detection.
    // The load sitting in ID/EX conflicts with the instruction in ID if its
    // destination matches either source. Register 0 is hard-wired to zero, so
    // a load targeting it never creates a dependency.
    // -----------------------------------------------------------------------
    logic [4:0] id_src [2];
    logic [1:0] src_match;
    logic       hz;

    assign id_src[0] = IF_ID_RegisterRs;
    assign id_src[1] = IF_ID_RegisterRt;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src_cmp
            assign src_match[gi] = (id_ex_rd_reg == id_src[gi]);
        end
    endgenerate

    assign hz = id_ex_mr_reg && (id_ex_rd_reg != 5'd0) && (|src_match);

    // -----------------------------------------------------------------------
    // Per-cycle control decisions.
    //   freeze : memory not ready, nothing moves
    //   bubble : ID/EX gets a NOP (flush has priority over the hazard)
    //   take   : a load-use stall cycle is being spent
    // -----------------------------------------------------------------------
    logic freeze;
    logic bubble;
    logic take_stall;

    assign freeze     = mem_stall_i;
    assign bubble     = !freeze && (flush_i || hz);
    assign take_stall = !freeze && !flush_i && hz;

    // -----------------------------------------------------------------------
    // Next-state logic. Defaults hold every register, so a freeze needs no
    // explicit branch of its own.
    // -----------------------------------------------------------------------
    always_comb begin
        id_ex_rs_next  = id_ex_rs_reg;
        id_ex_rt_next  = id_ex_rt_reg;
        id_ex_rd_next  = id_ex_rd_reg;
        id_ex_rw_next  = id_ex_rw_reg;
        id_ex_mr_next  = id_ex_mr_reg;
        ex_mem_rw_next = ex_mem_rw_reg;
        ex_mem_mr_next = ex_mem_mr_reg;
        ex_mem_rd_next = ex_mem_rd_reg;
        mem_wb_rw_next = mem_wb_rw_reg;
        mem_wb_rd_next = mem_wb_rd_reg;
        stall_cnt_next = stall_cnt_reg;

        if (!freeze) begin
            // Downstream stages always advance when not frozen; a bubble only
            // replaces what enters ID/EX.
            mem_wb_rw_next = ex_mem_rw_reg;
            mem_wb_rd_next = ex_mem_rd_reg;
            ex_mem_rw_next = id_ex_rw_reg;
            ex_mem_mr_next = id_ex_mr_reg;
            ex_mem_rd_next = id_ex_rd_reg;

            if (bubble) begin
                id_ex_rs_next = 5'd0;
                id_ex_rt_next = 5'd0;
                id_ex_rd_next = 5'd0;
                id_ex_rw_next = 1'b0;
                id_ex_mr_next = 1'b0;
            end else begin
                id_ex_rs_next = IF_ID_RegisterRs;
                id_ex_rt_next = IF_ID_RegisterRt;
                id_ex_rd_next = ID_RegisterRd;
                id_ex_rw_next = ID_RegWrite;
                id_ex_mr_next = ID_MemRead;
            end
        end

        // Saturating increment: all-ones is sticky.
        if (take_stall && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_next = stall_cnt_reg + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_ex_rs_reg  <= 5'd0;
            id_ex_rt_reg  <= 5'd0;
            id_ex_rd_reg  <= 5'd0;
            id_ex_rw_reg  <= 1'b0;
            id_ex_mr_reg  <= 1'b0;
            ex_mem_rw_reg <= 1'b0;
            ex_mem_mr_reg <= 1'b0;
            ex_mem_rd_reg <= 5'd0;
            mem_wb_rw_reg <= 1'b0;
            mem_wb_rd_reg <= 5'd0;
            stall_cnt_reg <= '0;
        end else begin
            id_ex_rs_reg  <= id_ex_rs_next;
            id_ex_rt_reg  <= id_ex_rt_next;
            id_ex_rd_reg  <= id_ex_rd_next;
            id_ex_rw_reg  <= id_ex_rw_next;
            id_ex_mr_reg  <= id_ex_mr_next;
            ex_mem_rw_reg <= ex_mem_rw_next;
            ex_mem_mr_reg <= ex_mem_mr_next;
            ex_mem_rd_reg <= ex_mem_rd_next;
            mem_wb_rw_reg <= mem_wb_rw_next;
            mem_wb_rd_reg <= mem_wb_rd_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign ID_EX_RegisterRs  = id_ex_rs_reg;
    assign ID_EX_RegisterRt  = id_ex_rt_reg;
    assign ID_EX_RegisterRd  = id_ex_rd_reg;
    assign ID_EX_RegWrite    = id_ex_rw_reg;
    assign ID_EX_MemRead     = id_ex_mr_reg;
    assign EX_MEM_RegWrite   = ex_mem_rw_reg;
    assign EX_MEM_MemRead    = ex_mem_mr_reg;
    assign EX_MEM_RegisterRd = ex_mem_rd_reg;
    assign MEM_WB_RegWrite   = mem_wb_rw_reg;
    assign MEM_WB_RegisterRd = mem_wb_rd_reg;
    assign stall_count       = stall_cnt_reg;

    // The front end advances unless memory is frozen or a load-use stall is
    // being taken; a flush always lets the corrected fetch proceed.
    assign PCWrite        = !freeze && !take_stall;
    assign IF_ID_Write    = !freeze && !take_stall;
    assign load_use_stall = take_stall;

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_pipe_ctrl
//
// Directed bench for hazard_pipe_ctrl. A small model holds the three stage
// contents as records and the stall count as an integer; every negative
// clock edge the DUT outputs are compared against it. Directed sequences
// also carry literal expectations worked out by hand.
// The counter is instantiated narrow so saturation is reachable quickly.
// ---------------------------------------------------------------------------
module tb_hazard_pipe_ctrl;

    localparam int TB_CNT_W = 8;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic       clk;
    logic       rst;
    logic [4:0] rs, rt, rd;
    logic       rw, mr, fl, ms;

    logic [4:0] id_ex_rs, id_ex_rt, id_ex_rd, ex_mem_rd, mem_wb_rd;
    logic       id_ex_rw, id_ex_mr, ex_mem_rw, ex_mem_mr, mem_wb_rw;
    logic       pc_write, if_id_write, lus;
    logic [TB_CNT_W-1:0] cnt;

    hazard_pipe_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .IF_ID_RegisterRs  (rs),
        .IF_ID_RegisterRt  (rt),
        .ID_RegisterRd     (rd),
        .ID_RegWrite       (rw),
        .ID_MemRead        (mr),
        .flush_i           (fl),
        .mem_stall_i       (ms),
        .ID_EX_RegisterRs  (id_ex_rs),
        .ID_EX_RegisterRt  (id_ex_rt),
        .ID_EX_RegisterRd  (id_ex_rd),
        .ID_EX_RegWrite    (id_ex_rw),
        .ID_EX_MemRead     (id_ex_mr),
        .EX_MEM_RegWrite   (ex_mem_rw),
        .EX_MEM_MemRead    (ex_mem_mr),
        .EX_MEM_RegisterRd (ex_mem_rd),
        .MEM_WB_RegWrite   (mem_wb_rw),
        .MEM_WB_RegisterRd (mem_wb_rd),
        .PCWrite           (pc_write),
        .IF_ID_Write       (if_id_write),
        .load_use_stall    (lus),
        .stall_count       (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model: one record per pipeline slot.
    // -----------------------------------------------------------------------
    typedef struct {
        bit       rw;
        bit       mr;
        bit [4:0] rs;
        bit [4:0] rt;
        bit [4:0] rd;
    } slot_t;

    slot_t slots [3];   // 0 = ID/EX, 1 = EX/MEM, 2 = MEM/WB
    int    m_cnt;
    bit    m_en = 1'b0;

    function automatic slot_t nop();
        slot_t s;
        s.rw = 0; s.mr = 0; s.rs = 0; s.rt = 0; s.rd = 0;
        return s;
    endfunction

    // Does the instruction now in ID depend on the load now in EX?
    function automatic bit m_hazard();
        return slots[0].mr && slots[0].rd != 0 &&
               (slots[0].rd == rs || slots[0].rd == rt);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) slots[i] = nop();
            m_cnt = 0;
            m_en  = 1'b1;
        end else if (m_en && !ms) begin
            slot_t incoming;
            bit    h;
            h = m_hazard();
            if (fl || h) begin
                incoming = nop();
            end else begin
                incoming.rw = rw; incoming.mr = mr;
                incoming.rs = rs; incoming.rt = rt; incoming.rd = rd;
            end
            slots[2] = slots[1];
            slots[1] = slots[0];
            slots[0] = incoming;
            if (!fl && h && m_cnt < CNT_MAX) m_cnt++;
        end
    end

    always @(negedge clk) begin
        if (m_en && !rst) begin
            bit h, exp_stall, exp_adv;
            h         = m_hazard();
            exp_stall = !ms && !fl && h;
            exp_adv   = !ms && !exp_stall;
            chk("id_ex_rs",  32'(id_ex_rs),    32'(slots[0].rs));
            chk("id_ex_rt",  32'(id_ex_rt),    32'(slots[0].rt));
            chk("id_ex_rd",  32'(id_ex_rd),    32'(slots[0].rd));
            chk("id_ex_rw",  32'(id_ex_rw),    32'(slots[0].rw));
            chk("id_ex_mr",  32'(id_ex_mr),    32'(slots[0].mr));
            chk("ex_mem_rw", 32'(ex_mem_rw),   32'(slots[1].rw));
            chk("ex_mem_mr", 32'(ex_mem_mr),   32'(slots[1].mr));
            chk("ex_mem_rd", 32'(ex_mem_rd),   32'(slots[1].rd));
            chk("mem_wb_rw", 32'(mem_wb_rw),   32'(slots[2].rw));
            chk("mem_wb_rd", 32'(mem_wb_rd),   32'(slots[2].rd));
            chk("pcwrite",   32'(pc_write),    32'(exp_adv));
            chk("if_id_wr",  32'(if_id_write), 32'(exp_adv));
            chk("lu_stall",  32'(lus),         32'(exp_stall));
            chk("stall_cnt", 32'(cnt),         32'(m_cnt));
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers: set() drives the ID inputs and lets them settle;
    // tick() advances one edge and returns just after it.
    // -----------------------------------------------------------------------
    task automatic set(input logic [4:0] s_rs, input logic [4:0] s_rt, input logic [4:0] s_rd,
                       input logic s_rw, input logic s_mr, input logic s_fl, input logic s_ms);
        rs = s_rs; rt = s_rt; rd = s_rd; rw = s_rw; mr = s_mr; fl = s_fl; ms = s_ms;
        #1;
        $display("t=%0t rs=%0d rt=%0d rd=%0d rw=%0b mr=%0b fl=%0b ms=%0b | pcw=%0b lus=%0b cnt=%0d",
                 $time, rs, rt, rd, rw, mr, fl, ms, pc_write, lus, cnt);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int budget;

        rst = 1'b1;
        set(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;

        // --- reset state ---
        set(0, 0, 0, 0, 0, 0, 0);
        chk("rst_id_ex_rd",  32'(id_ex_rd),  0);
        chk("rst_mem_wb_rd", 32'(mem_wb_rd), 0);
        chk("rst_pcwrite",   32'(pc_write),  1);
        chk("rst_lus",       32'(lus),       0);
        chk("rst_cnt",       32'(cnt),       0);

        // --- single writer walks the three stages ---
        set(0, 0, 5, 1, 0, 0, 0);
        tick();
        chk("p1_id_ex_rd",  32'(id_ex_rd),  5);
        chk("p1_id_ex_rw",  32'(id_ex_rw),  1);
        chk("p1_ex_mem_rd", 32'(ex_mem_rd), 0);
        set(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("p2_id_ex_rd",  32'(id_ex_rd),  0);
        chk("p2_ex_mem_rd", 32'(ex_mem_rd), 5);
        chk("p2_ex_mem_rw", 32'(ex_mem_rw), 1);
        chk("p2_mem_wb_rd", 32'(mem_wb_rd), 0);
        tick();
        chk("p3_ex_mem_rd", 32'(ex_mem_rd), 0);
        chk("p3_mem_wb_rd", 32'(mem_wb_rd), 5);
        chk("p3_mem_wb_rw", 32'(mem_wb_rw), 1);
        tick();
        chk("p4_mem_wb_rd", 32'(mem_wb_rd), 0);

        // --- load $8 followed by consumer of $8 ---
        set(0, 0, 8, 1, 1, 0, 0);
        tick();
        set(8, 3, 9, 1, 0, 0, 0);
        chk("lu_stall",   32'(lus),         1);
        chk("lu_pcwrite", 32'(pc_write),    0);
        chk("lu_ifid",    32'(if_id_write), 0);
        tick();
        chk("lu_bubble_rw", 32'(id_ex_rw), 0);
        chk("lu_cnt1",      32'(cnt),      1);
        chk("lu_cleared",   32'(lus),      0);
        chk("lu_pc_again",  32'(pc_write), 1);
        tick();
        chk("lu_consumer_rs", 32'(id_ex_rs),  8);
        chk("lu_load_in_wb",  32'(mem_wb_rd), 8);
        set(0, 0, 0, 0, 0, 0, 0);
        tick();

        // --- load to $0 never stalls ---
        set(0, 0, 0, 1, 1, 0, 0);
        tick();
        set(0, 0, 4, 1, 0, 0, 0);
        chk("r0_no_stall", 32'(lus), 0);
        tick();
        chk("r0_cnt", 32'(cnt), 1);

        // --- flush coincident with hazard ---
        set(0, 0, 8, 1, 1, 0, 0);
        tick();
        set(8, 0, 2, 1, 0, 1, 0);
        chk("fl_pcwrite", 32'(pc_write), 1);
        chk("fl_lus",     32'(lus),      0);
        tick();
        chk("fl_bubble_rw", 32'(id_ex_rw),  0);
        chk("fl_bubble_rs", 32'(id_ex_rs),  0);
        chk("fl_load_adv",  32'(ex_mem_mr), 1);
        chk("fl_cnt",       32'(cnt),       1);

        // --- memory freeze with a live hazard ---
        set(0, 0, 8, 1, 1, 0, 0);
        tick();
        set(8, 0, 6, 1, 0, 0, 1);
        chk("ms_pcwrite", 32'(pc_write), 0);
        chk("ms_lus",     32'(lus),      0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ms_hold_mr", 32'(id_ex_mr), 1);
            chk("ms_hold_rd", 32'(id_ex_rd), 8);
            chk("ms_hold_cnt", 32'(cnt),     1);
        end
        set(8, 0, 6, 1, 0, 0, 0);
        chk("ms_release_lus", 32'(lus), 1);
        tick();
        chk("ms_release_cnt", 32'(cnt), 2);

        // --- saturation: a self-dependent load held in ID stalls every other cycle ---
        set(8, 8, 8, 1, 1, 0, 0);
        budget = 0;
        while (cnt != TB_CNT_W'(CNT_MAX - 1) && budget < 2000) begin
            tick();
            budget++;
        end
        chk("sat_reach_fe", 32'(cnt), 32'(CNT_MAX - 1));
        seen = 0;
        for (int i = 0; i < 40 && seen < 3; i++) begin
            if (lus) seen++;
            tick();
        end
        chk("sat_three_stalls", 32'(seen), 3);
        chk("sat_value", 32'(cnt), 32'(CNT_MAX));

        // --- reset taken in a stall cycle ---
        budget = 0;
        while (!lus && budget < 10) begin
            tick();
            budget++;
        end
        chk("rst_mid_in_stall", 32'(lus), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set(0, 0, 0, 0, 0, 0, 0);
        chk("rm_id_ex_mr",  32'(id_ex_mr),  0);
        chk("rm_id_ex_rd",  32'(id_ex_rd),  0);
        chk("rm_ex_mem_mr", 32'(ex_mem_mr), 0);
        chk("rm_ex_mem_rd", 32'(ex_mem_rd), 0);
        chk("rm_mem_wb_rw", 32'(mem_wb_rw), 0);
        chk("rm_pcwrite",   32'(pc_write),  1);
        chk("rm_cnt",       32'(cnt),       0);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_pipe_ctrl.md
# hazard_pipe_ctrl

Control-side pipeline register chain and load-use hazard detector for the 5-stage MIPS core. Carries RegWrite, MemRead and register specifiers through the ID/EX, EX/MEM and MEM/WB stages. Its registered outputs are the signals the forwarding unit compares, so it is the producer side of the forwarding interface. It also stalls on load-use hazards, bubbles on branch flush, freezes on memory stall and keeps a saturating load-use stall counter.

## Interface
Parameters:
- CNT_W, 16, width of load-use stall counter

Ports:
- clk_i  input  1  core clock; all state updates on rising edge
- rst_i  input  1  synchronous, active-high reset
- IF_ID_RegisterRs  input  5  rs of instruction in ID
- IF_ID_RegisterRt  input  5  rt of instruction in ID
- ID_RegisterRd  input  5  destination of instruction in ID (already RegDst-muxed)
- ID_RegWrite  input  1  decoded RegWrite
- ID_MemRead  input  1  decoded MemRead
- flush_i  input  1  branch/jump taken; instruction in ID is wrong-path
- mem_stall_i  input  1  data/instruction memory not ready; freeze whole pipeline
- ID_EX_RegisterRs / ID_EX_RegisterRt / ID_EX_RegisterRd  output  5 each  ID/EX specifiers
- ID_EX_RegWrite / ID_EX_MemRead  output  1 each
- EX_MEM_RegWrite / EX_MEM_MemRead  output  1 each
- EX_MEM_RegisterRd  output  5
- MEM_WB_RegWrite  output  1
- MEM_WB_RegisterRd  output  5
- PCWrite  output  1  PC update enable
- IF_ID_Write  output  1  IF/ID register update enable
- load_use_stall  output  1  load-use hazard this cycle
- stall_count  output  CNT_W  saturating count of load-use stall cycles

## Operation
- Hazard (combinational from registered state): hz = ID_EX_MemRead & (ID_EX_RegisterRd != 0) & (ID_EX_RegisterRd == IF_ID_RegisterRs | ID_EX_RegisterRd == IF_ID_RegisterRt).
- Per-cycle priority, highest first:
  1. rst_i: all registers and counter cleared to 0.
  2. mem_stall_i: all three stage registers hold. PCWrite=0, IF_ID_Write=0, load_use_stall=0, counter holds.
  3. flush_i: ID/EX loads a bubble. EX/MEM and MEM/WB advance. PCWrite=1, IF_ID_Write=1. load_use_stall=0, counter holds. Flush overrides hz.
  4. hz: ID/EX loads a bubble. EX/MEM and MEM/WB advance. PCWrite=0, IF_ID_Write=0, load_use_stall=1. Counter increments, saturating at all-ones.
  5. Otherwise: ID/EX loads the ID inputs. EX/MEM takes ID/EX; MEM/WB takes EX/MEM. PCWrite=1, IF_ID_Write=1.
- Bubble: RegWrite=0, MemRead=0, Rs=Rt=Rd=0.
- EX/MEM copies RegWrite, MemRead and Rd from ID/EX. MEM/WB copies RegWrite and Rd from EX/MEM.
- No state machine beyond the stage registers. A stall is self-clearing because the bubble clears ID_EX_MemRead.

## Timing
- Reset values: every stage output is 0 and stall_count=0. PCWrite=1, IF_ID_Write=1 and load_use_stall=0 in the first cycle after reset, unless mem_stall_i is high.
- Stage latency is 1 cycle per stage. ID inputs appear on ID_EX_* after the next edge, on EX_MEM_* after 2 edges and on MEM_WB_* after 3 edges, absent stalls.
- Load-use sequence: load in EX at cycle N asserts hz in N with exactly one bubble. At N+1 the load is in MEM, a bubble is in EX and hz=0. At N+2 the consumer is in EX and the load is in WB, so the MEM_WB forward path applies.
- Back-to-back loads each produce at most one stall cycle.
- mem_stall_i held k cycles freezes all outputs for k cycles. Operation resumes on the first cycle it is low, with hz re-evaluated from the held state.
- Reset asserted during a stall or freeze clears everything on that edge. Reset has no pending effects.
- Counter at all-ones stays at all-ones.

## Test plan
- Reset, then ID_RegWrite=1, ID_RegisterRd=5 for one cycle, then zeros -> EX_MEM_RegisterRd=5 two edges later and MEM_WB_RegisterRd=5 three edges later; intermediate values exact.
- Load (MemRead=1, Rd=8) followed by an ID instruction with Rs=8 -> load_use_stall=1, PCWrite=0, IF_ID_Write=0 for exactly one cycle; ID_EX_RegWrite=0 next cycle; stall_count=1.
- Load with Rd=0 followed by Rs=0 -> no stall, stall_count unchanged.
- flush_i=1 in the same cycle as hz -> PCWrite=1, load_use_stall=0, ID/EX bubble, counter unchanged.
- mem_stall_i high 3 cycles with a live hazard -> all outputs held for 3 cycles, no count. When released, one stall cycle and stall_count +1.
- Preload the counter to 0xFFFE via repeated stalls (or force), then 3 more stalls -> saturates at 0xFFFF. rst_i mid-stall -> all outputs 0 and PCWrite=1 next cycle.
